pic_priority_ctrl: RTL

Clocked interrupt control core of the 8259A PIC. It sits between the command-word decoder and the data bus buffer. It owns IRR and ISR, resolves priority (fixed or rotating, fully nested) against the IMR, and raises INT. It sequences the two-pulse 8086 INTA cycle and drives the vector byte, and it executes OCW2 EOI and rotation commands.

---
 rtl/pic_pkg.sv | 30 +++
 rtl/pic_priority_resolver.sv | 54 +++++
 rtl/pic_priority_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pic_pkg.sv
// pic_pkg: shared types and constants for the 8259A priority/interrupt core.
//   pic_state_e : INTA sequencer states
//   OCW2_*      : OCW2 command codes, decoded from ocw2[7:5]
//   rotr8       : rotate-right helper used by the priority resolver
package pic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK1  = 2'd1,
    ST_WAIT2 = 2'd2,
    ST_VEC   = 2'd3
  } pic_state_e;

  localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] OCW2_NSEOI        = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_SEOI         = 3'b011;
  localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_NSEOI    = 3'b101;
  localparam logic [2:0] OCW2_SETPRI       = 3'b110;
  localparam logic [2:0] OCW2_ROT_SEOI     = 3'b111;

  // result[i] = v[(i + n) mod 8]
  function automatic logic [7:0] rotr8(input logic [7:0] v, input logic [2:0] n);
    logic [15:0] d;
    d = {v, v} >> n;
    return d[7:0];
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// pic_priority_resolver: combinational priority resolution.
//   req       : masked requests (irr & ~imr)
//   isr       : in-service register
//   lp        : lowest-priority level; lp+1 is the highest
//   win_valid : a request outranks every in-service level
//   win_id    : that request's IR level
//   isr_valid : isr is non-zero
//   isr_id    : highest-priority in-service level (non-specific EOI target)
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [7:0] req,
  input  logic [7:0] isr,
  input  logic [2:0] lp,
  output logic       win_valid,
  output logic [2:0] win_id,
  output logic       isr_valid,
  output logic [2:0] isr_id
);

  logic [2:0] base;
  logic [7:0] rot_req, rot_isr;
  logic       req_any, isr_any;
  logic [2:0] req_pos, isr_pos;

  // After rotation, bit 0 holds the highest-priority level.
  assign base    = lp + 3'd1;
  assign rot_req = rotr8(req, base);
  assign rot_isr = rotr8(isr, base);

  always_comb begin
    req_any = 1'b0;
    req_pos = 3'd0;
    isr_any = 1'b0;
    isr_pos = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot_req[i]) begin
        req_any = 1'b1;
        req_pos = 3'(i);
      end
      if (rot_isr[i]) begin
        isr_any = 1'b1;
        isr_pos = 3'(i);
      end
    end
  end

  // Fully nested: an in-service level at equal or higher rank blocks.
  assign win_valid = req_any && (!isr_any || (req_pos < isr_pos));
  assign win_id    = req_pos + base;
  assign isr_valid = isr_any;
  assign isr_id    = isr_pos + base;

endmodule

// File: rtl/pic_priority_ctrl.sv
// pic_priority_ctrl: 8259A interrupt control core (IRR/ISR, priority,
// INT, 8086 two-pulse INTA sequencing, OCW2 EOI/rotation).
//   clk, reset      : clock, async active-high reset
//   init            : ICW1 write pulse, synchronous re-initialisation
//   ltim, aeoi      : level-trigger mode, automatic EOI
//   vec_base        : vector high bits (ICW2[7:3])
//   imr             : interrupt mask, 1 = masked
//   ocw2, ocw2_wr   : OCW2 byte and its execute strobe
//   ir, inta_n      : asynchronous request lines and acknowledge
//   int_o           : interrupt to CPU
//   vec_out, vec_oe : vector byte and its bus enable
//   irr, isr        : register read-back
module pic_priority_ctrl
  import pic_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [2:0] SPURIOUS_ID = 3'd7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init,
  input  logic       ltim,
  input  logic       aeoi,
  input  logic [4:0] vec_base,
  input  logic [7:0] imr,
  input  logic [7:0] ocw2,
  input  logic       ocw2_wr,
  input  logic [7:0] ir,
  input  logic       inta_n,
  output logic       int_o,
  output logic [7:0] vec_out,
  output logic       vec_oe,
  output logic [7:0] irr,
  output logic [7:0] isr
);

  logic [SYNC_STAGES-1:0][7:0] ir_pipe;
  logic [SYNC_STAGES-1:0]      inta_pipe;
  logic [7:0] ir_s, ir_prev, ir_rise;
  logic       inta_s, inta_prev, inta_fall, inta_rise;

  pic_state_e state;
  logic [2:0] lp, cur_id;
  logic       rot_aeoi, spurious;

  logic       win_valid, isr_valid;
  logic [2:0] win_id, isr_id;

  logic [7:0] ack_set, aeoi_clr, eoi_clr;
  logic       aeoi_done, ocw_lp_wr, rot_set, rot_clr;
  logic [2:0] ocw_cmd, ocw_l, ocw_lp;
  logic       unused_ocw2_bits;

  assign unused_ocw2_bits = ^ocw2[4:3];

  // Synchronisers are not cleared by init so that a line already high
  // does not fake an edge after re-initialisation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_pipe   <= '0;
      inta_pipe <= '1;
      ir_prev   <= '0;
      inta_prev <= 1'b1;
    end else begin
      ir_pipe[0]   <= ir;
      inta_pipe[0] <= inta_n;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        ir_pipe[i]   <= ir_pipe[i-1];
        inta_pipe[i] <= inta_pipe[i-1];
      end
      ir_prev   <= ir_s;
      inta_prev <= inta_s;
    end
  end

  assign ir_s      = ir_pipe[SYNC_STAGES-1];
  assign inta_s    = inta_pipe[SYNC_STAGES-1];
  assign ir_rise   = ir_s & ~ir_prev;
  assign inta_fall = inta_prev & ~inta_s;
  assign inta_rise = ~inta_prev & inta_s;

  // One resolver serves both the INT/ACK winner and the NSEOI target.
  pic_priority_resolver u_res (
    .req       (irr & ~imr),
    .isr       (isr),
    .lp        (lp),
    .win_valid (win_valid),
    .win_id    (win_id),
    .isr_valid (isr_valid),
    .isr_id    (isr_id)
  );

  assign ack_set   = (state == ST_IDLE && inta_fall && win_valid) ? (8'b1 << win_id) : 8'h00;
  assign aeoi_done = (state == ST_VEC) && inta_rise && aeoi && !spurious;
  assign aeoi_clr  = aeoi_done ? (8'b1 << cur_id) : 8'h00;

  assign ocw_cmd = ocw2[7:5];
  assign ocw_l   = ocw2[2:0];

  always_comb begin
    eoi_clr   = 8'h00;
    ocw_lp_wr = 1'b0;
    ocw_lp    = ocw_l;
    rot_set   = 1'b0;
    rot_clr   = 1'b0;
    if (ocw2_wr) begin
      case (ocw_cmd)
        OCW2_NSEOI:
          if (isr_valid) eoi_clr = 8'b1 << isr_id;
        OCW2_ROT_NSEOI:
          if (isr_valid) begin
            eoi_clr   = 8'b1 << isr_id;
            ocw_lp_wr = 1'b1;
            ocw_lp    = isr_id;
          end
        OCW2_SEOI:
          if (isr_valid) eoi_clr = 8'b1 << ocw_l;
        OCW2_ROT_SEOI:
          if (isr_valid) begin
            eoi_clr   = 8'b1 << ocw_l;
            ocw_lp_wr = 1'b1;
          end
        OCW2_SETPRI:       ocw_lp_wr = 1'b1;
        OCW2_ROT_AEOI_SET: rot_set   = 1'b1;
        OCW2_ROT_AEOI_CLR: rot_clr   = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      irr      <= '0;
      isr      <= '0;
      lp       <= 3'd7;
      rot_aeoi <= 1'b0;
      int_o    <= 1'b0;
      vec_out  <= '0;
      vec_oe   <= 1'b0;
      cur_id   <= '0;
      spurious <= 1'b0;
    end else if (init) begin
      state    <= ST_IDLE;
      irr      <= '0;
      isr      <= '0;
      lp       <= 3'd7;
      rot_aeoi <= 1'b0;
      int_o    <= 1'b0;
      vec_out  <= '0;
      vec_oe   <= 1'b0;
      cur_id   <= '0;
      spurious <= 1'b0;
    end else begin
      // Edge mode: a new rising edge beats the ACK clear of the same bit.
      if (ltim) irr <= ir_s & ~ack_set;
      else      irr <= (irr & ~ack_set) | ir_rise;

      isr <= (isr & ~eoi_clr & ~aeoi_clr) | ack_set;

      if (ocw_lp_wr)                  lp <= ocw_lp;
      else if (aeoi_done && rot_aeoi) lp <= cur_id;

      if (rot_set)      rot_aeoi <= 1'b1;
      else if (rot_clr) rot_aeoi <= 1'b0;

      int_o <= win_valid && (state == ST_IDLE) && !inta_fall;

      case (state)
        ST_IDLE:
          if (inta_fall) begin
            state    <= ST_ACK1;
            cur_id   <= win_valid ? win_id : SPURIOUS_ID;
            spurious <= !win_valid;
          end
        ST_ACK1:
          if (inta_rise) state <= ST_WAIT2;
        ST_WAIT2:
          if (inta_fall) begin
            state   <= ST_VEC;
            vec_out <= {vec_base, cur_id};
            vec_oe  <= 1'b1;
          end
        ST_VEC:
          if (inta_rise) begin
            state  <= ST_IDLE;
            vec_oe <= 1'b0;
          end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
